// File: rtl/month_year.sv
// BCD month/year counter for the century clock: advances on day rollover,
// carries into a four-digit year, and accepts a validated parallel load.
module month_year #(
  parameter logic [15:0] YEAR_RST = 16'h2000,
  parameter logic [15:0] YEAR_MAX = 16'h9999,
  parameter logic [15:0] YEAR_MIN = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] ld_month_0,
  input  logic [3:0] ld_month_1,
  input  logic [3:0] ld_year_0,
  input  logic [3:0] ld_year_1,
  input  logic [3:0] ld_year_2,
  input  logic [3:0] ld_year_3,
  output logic [3:0] month_0,
  output logic [3:0] month_1,
  output logic [3:0] year_0,
  output logic [3:0] year_1,
  output logic [3:0] year_2,
  output logic [3:0] year_3,
  output logic       mm_to_yy_en,
  output logic       yy_wrap,
  output logic       load_ok,
  output logic       load_err
);

  logic [7:0]  month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        load_ok_q, load_err_q;
  logic [7:0]  ld_month;
  logic [15:0] ld_year;
  logic        ld_valid, state_valid, month_is_12;
  logic [15:0] year_inc;
  logic        carry;

  function automatic logic digits_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  // With every digit <= 9, packed BCD orders the same way as the decimal value.
  function automatic logic date_ok(input logic [7:0] m, input logic [15:0] y);
    return digits_ok({8'h00, m}) && digits_ok(y) && (m >= 8'h01) && (m <= 8'h12) &&
           (y >= YEAR_MIN) && (y <= YEAR_MAX);
  endfunction

  assign ld_month    = {ld_month_1, ld_month_0};
  assign ld_year     = {ld_year_3, ld_year_2, ld_year_1, ld_year_0};
  assign ld_valid    = date_ok(ld_month, ld_year);
  assign state_valid = date_ok(month_q, year_q);
  assign month_is_12 = (month_q == 8'h12);

  // An invalid state only resets the month, so no year carry is announced.
  assign mm_to_yy_en = en & ~load & state_valid & month_is_12;
  assign yy_wrap     = mm_to_yy_en & (year_q == YEAR_MAX);

  always_comb begin
    year_inc = year_q;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (year_q[4*i +: 4] == 4'd9) begin
          year_inc[4*i +: 4] = 4'd0;
        end else begin
          year_inc[4*i +: 4] = year_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    month_d = month_q;
    year_d  = year_q;
    if (load) begin
      if (ld_valid) begin
        month_d = ld_month;
        year_d  = ld_year;
      end
    end else if (en) begin
      if (!state_valid) begin
        month_d = 8'h01;
      end else if (month_is_12) begin
        month_d = 8'h01;
        year_d  = (year_q == YEAR_MAX) ? YEAR_MIN : year_inc;
      end else if (month_q[3:0] == 4'd9) begin
        month_d = {month_q[7:4] + 4'd1, 4'd0};
      end else begin
        month_d = {month_q[7:4], month_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      month_q    <= 8'h01;
      year_q     <= YEAR_RST;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      month_q    <= month_d;
      year_q     <= year_d;
      load_ok_q  <= load & ld_valid;
      load_err_q <= load & ~ld_valid;
    end
  end

  assign month_0  = month_q[3:0];
  assign month_1  = month_q[7:4];
  assign year_0   = year_q[3:0];
  assign year_1   = year_q[7:4];
  assign year_2   = year_q[11:8];
  assign year_3   = year_q[15:12];
  assign load_ok  = load_ok_q;
  assign load_err = load_err_q;

endmodule

// File: doc/month_year.md
# month_year

Calendar month and year counter for the century clock, directly downstream of the day stage. It advances the BCD month on each day-rollover pulse and carries into a four-digit BCD year. Its month and year digits feed back to the day stage for month-length and leap-year decisions. A validated parallel load sets the date from the user-set path.

## Interface
Parameters:
- `YEAR_RST`, 16'h2000: year loaded on reset, as four packed BCD digits {year_3, year_2, year_1, year_0}.
- `YEAR_MAX`, 16'h9999: last year before wrap, packed BCD.
- `YEAR_MIN`, 16'h0000: year after wrap, packed BCD.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  day-rollover pulse from the day stage (`dd_to_mm_en`); one cycle per rollover.
- `load`  in  1  single-cycle request to load the `ld_*` digits.
- `ld_month_0`, `ld_month_1`  in  4 each  month digits to load (units, tens).
- `ld_year_0` … `ld_year_3`  in  4 each  year digits to load (units … thousands).
- `month_0`, `month_1`  out  4 each  current month in BCD (units, tens), registered.
- `year_0` … `year_3`  out  4 each  current year in BCD (units … thousands), registered.
- `mm_to_yy_en`  out  1  combinational: `en` & month == 12 (the year advances on this edge).
- `yy_wrap`  out  1  combinational: `mm_to_yy_en` & year == `YEAR_MAX`.
- `load_ok`  out  1  registered one-cycle pulse: the load was accepted.
- `load_err`  out  1  registered one-cycle pulse: the load was rejected.

## Operation
- Register priority each edge: `rst` > `load` > `en` > hold.
- **Reset:** month = 01, year = `YEAR_RST`, `load_ok` = 0, `load_err` = 0.
- **Month advance (en = 1, no load):**
  - 01→02 … 08→09 increments the units digit.
  - 09→10 sets units to 0 and tens to 1.
  - 10→11 and 11→12 increment the units digit.
  - 12→01, with `mm_to_yy_en` = 1 that cycle.
- **Year advance (same edge as 12→01):** BCD increment with ripple carry.
  - Each digit goes 9→0 and carries into the next digit.
  - Year == `YEAR_MAX` goes to `YEAR_MIN`, with `yy_wrap` = 1.
- **Load validation:** accepted only if all of the following hold:
  - every `ld_*` digit ≤ 9;
  - month is in 01..12;
  - year is in `YEAR_MIN`..`YEAR_MAX`, compared as packed BCD.
- **Accepted load:** all six digits update on the edge; `load_ok` = 1 the next cycle.
- **Rejected load:** no state change; `load_err` = 1 the next cycle.
- **load and en in the same cycle:** load wins and `en` is discarded. `mm_to_yy_en` and `yy_wrap` are forced to 0 in any cycle with `load` = 1.
- **Out-of-range state:** if state is ever invalid (e.g. an upset), the next `en` forces month = 01 and does not advance the year.
- Month and year outputs are driven directly from the registers.

## Timing
- `en` at edge N: new month/year visible after edge N. Latency is 1 cycle.
- `mm_to_yy_en` and `yy_wrap` are asserted in the same cycle as `en` (zero latency). They are combinational from `en` and the current state, for chaining.
- `load` at edge N:
  - accepted: digits updated after N, `load_ok` high for the cycle after N;
  - rejected: `load_err` high for the cycle after N.
- `load_ok` and `load_err` are never high together and never high for more than one cycle per request.
- Back-to-back `en` on consecutive cycles each advance one month; no dead cycle.
- `rst` asserted mid-load or mid-rollover: the reset values are applied at that edge and no pulses are produced the following cycle.
- With `en` held low, the outputs are stable indefinitely.

## Test plan
- **Reset:** assert `rst` for 2 cycles → month 01, year 2000, all pulses 0.
- **Full-year rollover:** from 01/2000, apply 12 `en` pulses → months step 02…12 then 01. `mm_to_yy_en` is high only on the 12th pulse; year becomes 2001.
- **Carry and wrap:**
  - load 12/2099, pulse `en` → 01/2100 with ripple carry;
  - load 12/9999, pulse `en` → 01/0000 and `yy_wrap` = 1.
- **Load validation:**
  - load 13/2024 → `load_err`, state unchanged;
  - load month 0x0A → `load_err`;
  - load 00/2024 → `load_err`;
  - load 09/2024 → `load_ok`, outputs 09/2024.
- **Priority:**
  - at 12/2023, `load` 05/2030 together with `en` → 05/2030, `mm_to_yy_en` = 0;
  - `rst` together with `load` → 01/2000, no `load_ok`.
- **Back-to-back:** `en` high for 3 consecutive cycles from 11/2023 → 12/2023, 01/2024, 02/2024, with one `mm_to_yy_en` on the second cycle.
